// File: rtl/axi_slave_mem.sv
// AXI4 memory-mapped slave: word-organised RAM behind independent write and read FSMs.
// Supports FIXED/INCR/WRAP bursts, byte strobes, ID echo and SLVERR on illegal bursts.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int MEM_BYTES = MEM_DEPTH * STRB_W;
  localparam int AW1       = ADDR_WIDTH + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic [ADDR_WIDTH-1:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << size;
    mask = wrap_mask(len, size);
    case (burst)
      2'b00:   next_addr = addr;
      2'b01:   next_addr = addr + step;
      2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: next_addr = addr;
    endcase
  endfunction

  function automatic logic cfg_err(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    cfg_err = (size > 3'(OFF_W)) || (burst == 2'b11) || bad_wrap;
  endfunction

  function automatic logic beat_oob(input logic [ADDR_WIDTH-1:0] addr);
    beat_oob = addr >= ADDR_WIDTH'(MEM_BYTES);
  endfunction

  // Highest byte address any beat of the burst can touch, checked up front.
  function automatic logic burst_oob(input logic [ADDR_WIDTH-1:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [AW1-1:0] top;
    case (burst)
      2'b01:   top = {1'b0, addr} + (AW1'(len) << size);
      2'b10:   top = {1'b0, addr | wrap_mask(len, size)};
      default: top = {1'b0, addr};
    endcase
    burst_oob = top >= AW1'(MEM_BYTES);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d, wid_q, wid_d;
  logic [1:0]            bresp_q, bresp_d, wburst_q, wburst_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]            wsize_q, wsize_d;
  logic                  werr_q, werr_d, wdrop_q, wdrop_d, mem_we_s;

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word_s;
  logic [1:0]            rresp_q, rresp_d, rburst_q, rburst_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rd_addr_s;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic                  rdrop_q, rdrop_d, rd_drop_s;

  // Write FSM: AW capture, strobed beat writes, B response.
  always_comb begin
    w_state_d = w_state_q; awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
    bid_d = bid_q; bresp_d = bresp_q; wid_d = wid_q; waddr_d = waddr_q; wlen_d = wlen_q;
    wsize_d = wsize_q; wburst_d = wburst_q; wcnt_d = wcnt_q; werr_d = werr_q; wdrop_d = wdrop_q;
    mem_we_s = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          wid_d = awid; waddr_d = awaddr; wlen_d = awlen; wsize_d = awsize; wburst_d = awburst;
          wcnt_d = 8'd0;
          wdrop_d = cfg_err(awlen, awsize, awburst);
          werr_d = cfg_err(awlen, awsize, awburst) || burst_oob(awaddr, awlen, awsize, awburst);
          awready_d = 1'b0; wready_d = 1'b1; w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          mem_we_s = !wdrop_q && !beat_oob(waddr_q);
          waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
          wcnt_d = wcnt_q + 8'd1;
          if (wlast) begin
            // Early or late wlast still closes the burst, but with an error response.
            bresp_d = (werr_q || (wcnt_q != wlen_q)) ? RESP_SLVERR : RESP_OKAY;
            bid_d = wid_q; bvalid_d = 1'b1; wready_d = 1'b0; w_state_d = W_RESP;
          end else if (wcnt_q == wlen_q) begin
            werr_d = 1'b1;
          end else begin
            werr_d = werr_q;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0; bresp_d = RESP_OKAY; bid_d = {ID_WIDTH{1'b0}};
          awready_d = 1'b1; w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read-side word fetch: AR address while idle, otherwise the pending beat address.
  always_comb begin
    rd_addr_s = (r_state_q == R_IDLE) ? araddr : raddr_q;
    rd_drop_s = beat_oob(rd_addr_s) ||
                ((r_state_q == R_IDLE) ? cfg_err(arlen, arsize, arburst) : rdrop_q);
    rd_word_s = rd_drop_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_addr_s[OFF_W +: IDX_W]];
  end

  // Read FSM: beat 0 follows the AR handshake, further beats follow each R handshake.
  always_comb begin
    r_state_d = r_state_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
    rid_d = rid_q; rdata_d = rdata_q; rresp_d = rresp_q; raddr_d = raddr_q; rlen_d = rlen_q;
    rsize_d = rsize_q; rburst_d = rburst_q; rcnt_d = rcnt_q; rdrop_d = rdrop_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          rid_d = arid; rlen_d = arlen; rsize_d = arsize; rburst_d = arburst;
          rdrop_d = cfg_err(arlen, arsize, arburst);
          rresp_d = (cfg_err(arlen, arsize, arburst) || burst_oob(araddr, arlen, arsize, arburst))
                    ? RESP_SLVERR : RESP_OKAY;
          raddr_d = next_addr(araddr, arlen, arsize, arburst);
          rdata_d = rd_word_s; rcnt_d = 8'd0; rlast_d = (arlen == 8'd0);
          rvalid_d = 1'b1; arready_d = 1'b0; r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (rready && rvalid_q) begin
          if (rlast_q) begin
            rvalid_d = 1'b0; rlast_d = 1'b0; rdata_d = {DATA_WIDTH{1'b0}};
            rresp_d = RESP_OKAY; rid_d = {ID_WIDTH{1'b0}}; arready_d = 1'b1; r_state_d = R_IDLE;
          end else begin
            rdata_d = rd_word_s; rcnt_d = rcnt_q + 8'd1; rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
          end
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[waddr_q[OFF_W +: IDX_W]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // State and output registers for both channel directions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE; awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
      bid_q <= {ID_WIDTH{1'b0}}; bresp_q <= 2'b00; wid_q <= {ID_WIDTH{1'b0}};
      waddr_q <= {ADDR_WIDTH{1'b0}}; wlen_q <= 8'd0; wsize_q <= 3'd0; wburst_q <= 2'b00;
      wcnt_q <= 8'd0; werr_q <= 1'b0; wdrop_q <= 1'b0;
      r_state_q <= R_IDLE; arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      rid_q <= {ID_WIDTH{1'b0}}; rdata_q <= {DATA_WIDTH{1'b0}}; rresp_q <= 2'b00;
      raddr_q <= {ADDR_WIDTH{1'b0}}; rlen_q <= 8'd0; rsize_q <= 3'd0; rburst_q <= 2'b00;
      rcnt_q <= 8'd0; rdrop_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      bid_q <= bid_d; bresp_q <= bresp_d; wid_q <= wid_d; waddr_q <= waddr_d; wlen_q <= wlen_d;
      wsize_q <= wsize_d; wburst_q <= wburst_d; wcnt_q <= wcnt_d; werr_q <= werr_d;
      wdrop_q <= wdrop_d;
      r_state_q <= r_state_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      rid_q <= rid_d; rdata_q <= rdata_d; rresp_q <= rresp_d; raddr_q <= raddr_d;
      rlen_q <= rlen_d; rsize_q <= rsize_d; rburst_q <= rburst_d; rcnt_q <= rcnt_d;
      rdrop_q <= rdrop_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem: reset, single/INCR/WRAP/FIXED bursts,
// byte strobes, error responses and reset in the middle of a write burst.
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] wbeat [16];
  logic [3:0]  wstrbv [16];
  logic [31:0] r_data [16];
  logic [1:0]  r_resp [16];
  logic [3:0]  r_id [16];
  logic        r_last [16];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic [31:0] exp_wrap [4];

  axi_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nbeats);
    int t;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    @(negedge clk); t = 0;
    while (!awready && t < 100) begin @(negedge clk); t++; end
    check_eq("awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbeat[i]; wstrb = wstrbv[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      @(negedge clk); t = 0;
      while (!wready && t < 100) begin @(negedge clk); t++; end
      check_eq("wready", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge clk); t = 0;
    while (!bvalid && t < 100) begin @(negedge clk); t++; end
    check_eq("bvalid", bvalid, 1);
    b_resp = bresp; b_id = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int t, nb, cyc;
    logic held_v;
    logic [31:0] held_d;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge clk); t = 0;
    while (!arready && t < 100) begin @(negedge clk); t++; end
    check_eq("arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    nb = 0; cyc = 0; held_v = 1'b0; held_d = 32'h0;
    while (nb <= int'(len) && nb < 16 && cyc < 200) begin
      rready = toggle ? cyc[0] : 1'b1;
      @(negedge clk);
      if (rvalid) begin
        if (held_v) check_eq("r_stable", rdata, held_d);
        if (rready) begin
          r_data[nb] = rdata; r_resp[nb] = rresp; r_id[nb] = rid; r_last[nb] = rlast;
          nb++; held_v = 1'b0;
        end else begin
          held_v = 1'b1; held_d = rdata;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    check_eq("r_beats", nb, int'(len) + 1);
  endtask

  initial begin
    rst = 1'b0;
    awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
    rready = 1'b0;

    // Reset state and first cycle after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid}, 0);
    check_eq("rst_rdata", rdata, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rel_awready", awready, 1);
    check_eq("rel_arready", arready, 1);

    // Single write then read
    wbeat[0] = 32'hDEADBEEF; wstrbv[0] = 4'hF;
    axi_write(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 1);
    check_eq("single_bid", b_id, 3);
    check_eq("single_bresp", b_resp, 0);
    axi_read(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("single_rdata", r_data[0], 32'hDEADBEEF);
    check_eq("single_rid", r_id[0], 5);
    check_eq("single_rlast", r_last[0], 1);
    check_eq("single_rresp", r_resp[0], 0);

    // INCR burst with stalled read-back
    for (int i = 0; i < 4; i++) begin wbeat[i] = 32'(i + 1); wstrbv[i] = 4'hF; end
    axi_write(4'd1, 32'h20, 8'd3, 3'd2, 2'b01, 4);
    check_eq("incr_bresp", b_resp, 0);
    axi_read(4'd2, 32'h20, 8'd3, 3'd2, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("incr_rdata", r_data[i], 32'(i + 1));
      check_eq("incr_rlast", r_last[i], (i == 3));
      check_eq("incr_rid", r_id[i], 2);
    end

    // WRAP read: 0x28, 0x2C, 0x20, 0x24 hold 3, 4, 1, 2
    exp_wrap[0] = 32'd3; exp_wrap[1] = 32'd4; exp_wrap[2] = 32'd1; exp_wrap[3] = 32'd2;
    axi_read(4'd7, 32'h28, 8'd3, 3'd2, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("wrap_rdata", r_data[i], exp_wrap[i]);
      check_eq("wrap_rlast", r_last[i], (i == 3));
      check_eq("wrap_rresp", r_resp[i], 0);
    end

    // Byte strobes over a zeroed word
    wbeat[0] = 32'h0; wstrbv[0] = 4'hF;
    axi_write(4'd0, 32'h30, 8'd0, 3'd2, 2'b01, 1);
    wbeat[0] = 32'hAABBCCDD; wstrbv[0] = 4'h5;
    axi_write(4'd0, 32'h30, 8'd0, 3'd2, 2'b01, 1);
    axi_read(4'd0, 32'h30, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("strb_rdata", r_data[0], 32'h00BB00DD);

    // FIXED write keeps only the last beat
    wbeat[0] = 32'h11111111; wstrbv[0] = 4'hF; wbeat[1] = 32'h22222222; wstrbv[1] = 4'hF;
    axi_write(4'd4, 32'h40, 8'd1, 3'd2, 2'b00, 2);
    check_eq("fixed_bresp", b_resp, 0);
    axi_read(4'd4, 32'h40, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("fixed_rdata", r_data[0], 32'h22222222);

    // Out-of-range read
    axi_read(4'd6, 32'h1000, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("oob_rresp", r_resp[0], 2);
    check_eq("oob_rdata", r_data[0], 0);
    check_eq("oob_rlast", r_last[0], 1);

    // Early wlast, then a normal write recovers
    wbeat[0] = 32'hA0; wbeat[1] = 32'hA1; wstrbv[0] = 4'hF; wstrbv[1] = 4'hF;
    axi_write(4'd8, 32'h60, 8'd2, 3'd2, 2'b01, 2);
    check_eq("short_bresp", b_resp, 2);
    check_eq("short_bid", b_id, 8);
    wbeat[0] = 32'h12345678;
    axi_write(4'd9, 32'h60, 8'd0, 3'd2, 2'b01, 1);
    check_eq("recover_bresp", b_resp, 0);
    check_eq("recover_bid", b_id, 9);

    // Illegal size, illegal WRAP length, reserved burst, burst crossing the top
    axi_read(4'd1, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);
    check_eq("size_rresp", r_resp[0], 2);
    check_eq("size_rdata", r_data[0], 0);
    axi_read(4'd1, 32'h20, 8'd2, 3'd2, 2'b10, 1'b0);
    check_eq("wraplen_rresp", r_resp[0], 2);
    wbeat[0] = 32'h0;
    axi_write(4'd2, 32'h10, 8'd0, 3'd2, 2'b11, 1);
    check_eq("rsvd_bresp", b_resp, 2);
    axi_read(4'd0, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("rsvd_nowrite", r_data[0], 32'hDEADBEEF);
    wbeat[0] = 32'h1; wbeat[1] = 32'h2;
    axi_write(4'd3, 32'hFFC, 8'd1, 3'd2, 2'b01, 2);
    check_eq("cross_bresp", b_resp, 2);

    // Reset in the middle of a write burst keeps completed beats
    @(posedge clk); #1;
    awid = 4'd1; awaddr = 32'h50; awlen = 8'd1; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    check_eq("mid_awready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wdata = 32'h5A5A5A5A; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    check_eq("mid_wready", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_wready", wready, 0);
    check_eq("mid_rst_awready", awready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rel_awready", awready, 1);
    axi_read(4'd2, 32'h50, 8'd0, 3'd2, 2'b01, 1'b0);
    check_eq("mid_kept_data", r_data[0], 32'h5A5A5A5A);
    check_eq("mid_kept_rresp", r_resp[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
